trisc_datapath: RTL and testbench
=================================

# trisc_datapath

Datapath for the TRISC processor. It executes the control strobes C0–C11 issued each cycle by the TRISC controller FSM, and returns the decoded instruction lines INCA/CLRA/LDA/STA/ADD/JMP that the controller branches on. It holds the PC, the memory data register (MDR), the instruction register (IR), the accumulator (ACC), a small ALU, and a synchronous single-port program/data memory.

## Interface
Parameters:
- DW, 8: data/instruction width; DW = AW + 3 (3-bit opcode in [DW-1:AW], address in [AW-1:0]).
- AW, 5: address width; memory depth 2^AW words.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- CLR_n  in  1  asynchronous, active-low reset.
- C0  in  1  clear PC.
- C1  in  1  load PC from MDR[AW-1:0] (jump).
- C2  in  1  increment PC.
- C3  in  1  address select: 0 = PC, 1 = MDR[AW-1:0].
- C4  in  1  memory enable.
- C5  in  1  write qualifier; with C4, writes ACC to memory.
- C42  in  1  load MDR from memory read data.
- C6  in  1  ALU op: 0 = ACC + MDR, 1 = ACC − MDR.
- C7  in  1  load IR from MDR[DW-1:AW].
- C8  in  1  clear ACC.
- C9  in  1  increment ACC.
- C10  in  1  ACC source: 0 = MDR, 1 = ALU.
- C11  in  1  load ACC from the selected source.
- INCA, CLRA, LDA, STA, ADD, JMP  out  1 each  one-hot opcode decode of IR.
- ACC_out  out  DW  accumulator.
- PC_out  out  AW  program counter.
- ERR  out  1  sticky strobe-conflict flag.

## Operation
- Effective address: C3 ? MDR[AW-1:0] : PC.
- Memory:
  - C4 & !C5: rdata <= mem[addr].
  - C4 & C5: mem[addr] <= ACC; rdata holds its value.
- C42: MDR <= rdata.
- C7: IR <= MDR[DW-1:AW].
- PC priority C0 > C1 > C2.
  - C2 increments modulo 2^AW, so PC wraps 2^AW−1 → 0.
- ACC priority C8 > C9 > C11.
  - C9 and the ALU are modulo 2^DW; there is no overflow flag.
  - C11 loads ACC from MDR or ALU according to C10.
- Opcode decode (combinational from IR): 000 INCA, 001 CLRA, 010 LDA, 011 STA, 100 ADD, 101 JMP. Codes 110 and 111 drive all decode lines low (NOP); the controller then returns to fetch.
- ERR sets when two or more of {C0, C1, C2} are high in the same cycle, or two or more of {C8, C9, C11}. It also sets on C42 & C4 & C5 in the same cycle. ERR clears only on reset. The priority rules still apply when ERR sets.
- Reset values: PC 0, ACC 0, MDR 0, rdata 0, IR 3'b111 (all decode lines 0), ERR 0, carry 0 (when present). Memory contents are not reset.
- Asserting CLR_n low mid-instruction returns all registers to their reset values immediately. A write strobed in the same edge as reset assertion is not guaranteed.

## Timing
- Memory read latency is 1 cycle. C4 in cycle t presents data on rdata after edge t. C42 in cycle t+1 captures it into MDR after edge t+1. This matches the controller's read state followed by its transfer state.
- Memory write completes at the edge ending the C4 & C5 cycle. A read of the same address in the next cycle returns the new value.
- Decode lines are valid 1 cycle after C7 and are stable until the next C7 or reset.
- Register updates take effect at the edge ending the cycle in which their strobe is high. ACC_out and PC_out reflect them immediately after that edge.
- No input is registered. Strobes are sampled at the edge only.

## Configuration
- TRISC_CARRY_FLAG_EN
  - Defined: adds output port CARRY (1 bit), which loads the ALU carry-out (add) or borrow (subtract) on C11 & C10. C8 clears it. C9 and C11 & !C10 leave it unchanged. Reset value 0.
  - Undefined: no CARRY port and no carry register; the ALU is DW bits wide.

## Test plan
- Reset and fetch: mem[0]=8'h00. Deassert CLR_n, then strobe C4 → C42 → C2 & C7 → IR=000, INCA=1, PC_out=1. All other outputs are 0 while in reset.
- Load: mem[1]=8'h4A (LDA 10), mem[10]=8'h37. Strobe C3 & C4, then C42, then C11 with C10=0 → ACC_out=8'h37.
- Store and readback: ACC=8'h5C, MDR[4:0]=20. Strobe C3 & C4 & C5, then C3 & C4, then C42 → MDR=8'h5C.
- ADD wrap: ACC=8'hF0, MDR=8'h20. C6=0, C10=1, C11 → ACC=8'h10; CARRY=1 when TRISC_CARRY_FLAG_EN is defined.
- PC wrap and jump: PC=31, C2 → PC=0. MDR=8'hA7, C1 → PC=7. C0 & C2 together → PC=0 and ERR=1, held until CLR_n low.
- Reset mid-load: CLR_n low in the cycle after C4 → MDR, ACC, PC = 0, IR = NOP, and all decode lines 0.

Source files
------------

// File: rtl/trisc_datapath.sv
// TRISC datapath: PC, MDR, IR, ACC, ALU and single-port program/data memory.
// Optional: define TRISC_CARRY_FLAG_EN to add the CARRY output and its register.
module trisc_datapath #(
    parameter int DW = 8,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          CLR_n,
    input  logic          C0,
    input  logic          C1,
    input  logic          C2,
    input  logic          C3,
    input  logic          C4,
    input  logic          C5,
    input  logic          C42,
    input  logic          C6,
    input  logic          C7,
    input  logic          C8,
    input  logic          C9,
    input  logic          C10,
    input  logic          C11,
    output logic          INCA,
    output logic          CLRA,
    output logic          LDA,
    output logic          STA,
    output logic          ADD,
    output logic          JMP,
    output logic [DW-1:0] ACC_out,
    output logic [AW-1:0] PC_out,
`ifdef TRISC_CARRY_FLAG_EN
    output logic          CARRY,
`endif
    output logic          ERR
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [2:0] {
        OP_INCA = 3'b000,
        OP_CLRA = 3'b001,
        OP_LDA  = 3'b010,
        OP_STA  = 3'b011,
        OP_ADD  = 3'b100,
        OP_JMP  = 3'b101,
        OP_NOP6 = 3'b110,
        OP_NOP7 = 3'b111
    } op_e;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q, rdata_d;
    logic [DW-1:0] mdr_q, mdr_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [AW-1:0] pc_q, pc_d;
    op_e           ir_q, ir_d;
    logic          err_q, err_d;
    logic [AW-1:0] addr;
    logic [DW-1:0] alu_res;
    logic          mem_wr;
`ifdef TRISC_CARRY_FLAG_EN
    logic          carry_q, carry_d;
    logic [DW:0]   alu_full;
`endif

    assign addr   = C3 ? mdr_q[AW-1:0] : pc_q;
    assign mem_wr = C4 & C5;

    always_comb begin
`ifdef TRISC_CARRY_FLAG_EN
        // Extra top bit is the carry on add and the borrow on subtract.
        alu_full = C6 ? ({1'b0, acc_q} - {1'b0, mdr_q}) : ({1'b0, acc_q} + {1'b0, mdr_q});
        alu_res  = alu_full[DW-1:0];
`else
        alu_res  = C6 ? (acc_q - mdr_q) : (acc_q + mdr_q);
`endif
    end

    always_comb begin
        rdata_d = rdata_q;
        if (C4 && !C5) rdata_d = mem_q[addr];

        mdr_d = C42 ? rdata_q : mdr_q;
        ir_d  = C7 ? op_e'(mdr_q[DW-1:AW]) : ir_q;

        pc_d = pc_q;
        if (C0)      pc_d = '0;
        else if (C1) pc_d = mdr_q[AW-1:0];
        else if (C2) pc_d = pc_q + 1'b1;

        acc_d = acc_q;
        if (C8)       acc_d = '0;
        else if (C9)  acc_d = acc_q + 1'b1;
        else if (C11) acc_d = C10 ? alu_res : mdr_q;

`ifdef TRISC_CARRY_FLAG_EN
        // Follows ACC priority: only an ALU result actually landing in ACC updates it.
        carry_d = carry_q;
        if (C8)                   carry_d = 1'b0;
        else if (!C9 && C11 && C10) carry_d = alu_full[DW];
`endif

        err_d = err_q | (C0 & C1) | (C0 & C2) | (C1 & C2)
                      | (C8 & C9) | (C8 & C11) | (C9 & C11)
                      | (C42 & C4 & C5);
    end

    always_ff @(posedge clk) begin
        if (mem_wr) mem_q[addr] <= acc_q;
    end

    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n) begin
            rdata_q <= '0;
            mdr_q   <= '0;
            acc_q   <= '0;
            pc_q    <= '0;
            ir_q    <= OP_NOP7;
            err_q   <= 1'b0;
`ifdef TRISC_CARRY_FLAG_EN
            carry_q <= 1'b0;
`endif
        end else begin
            rdata_q <= rdata_d;
            mdr_q   <= mdr_d;
            acc_q   <= acc_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            err_q   <= err_d;
`ifdef TRISC_CARRY_FLAG_EN
            carry_q <= carry_d;
`endif
        end
    end

    always_comb begin
        INCA = 1'b0;
        CLRA = 1'b0;
        LDA  = 1'b0;
        STA  = 1'b0;
        ADD  = 1'b0;
        JMP  = 1'b0;
        case (ir_q)
            OP_INCA: INCA = 1'b1;
            OP_CLRA: CLRA = 1'b1;
            OP_LDA:  LDA  = 1'b1;
            OP_STA:  STA  = 1'b1;
            OP_ADD:  ADD  = 1'b1;
            OP_JMP:  JMP  = 1'b1;
            default: ;
        endcase
    end

    assign ACC_out = acc_q;
    assign PC_out  = pc_q;
    assign ERR     = err_q;
`ifdef TRISC_CARRY_FLAG_EN
    assign CARRY   = carry_q;
`endif

endmodule

// File: tb/tb_trisc_datapath.sv
// Directed self-checking bench for trisc_datapath; memory is preloaded through the datapath itself.
module tb_trisc_datapath;

    localparam logic [12:0] S_C0  = 13'h0001;
    localparam logic [12:0] S_C1  = 13'h0002;
    localparam logic [12:0] S_C2  = 13'h0004;
    localparam logic [12:0] S_C3  = 13'h0008;
    localparam logic [12:0] S_C4  = 13'h0010;
    localparam logic [12:0] S_C5  = 13'h0020;
    localparam logic [12:0] S_C6  = 13'h0040;
    localparam logic [12:0] S_C7  = 13'h0080;
    localparam logic [12:0] S_C8  = 13'h0100;
    localparam logic [12:0] S_C9  = 13'h0200;
    localparam logic [12:0] S_C10 = 13'h0400;
    localparam logic [12:0] S_C11 = 13'h0800;
    localparam logic [12:0] S_C42 = 13'h1000;

    logic       clk = 1'b0;
    logic       CLR_n;
    logic       C0, C1, C2, C3, C4, C5, C42, C6, C7, C8, C9, C10, C11;
    logic       INCA, CLRA, LDA, STA, ADD, JMP, ERR;
    logic [7:0] ACC_out;
    logic [4:0] PC_out;
`ifdef TRISC_CARRY_FLAG_EN
    logic       CARRY;
`endif

    int checks   = 0;
    int failures = 0;

    trisc_datapath #(.DW(8), .AW(5)) dut (
        .clk(clk), .CLR_n(CLR_n),
        .C0(C0), .C1(C1), .C2(C2), .C3(C3), .C4(C4), .C5(C5), .C42(C42),
        .C6(C6), .C7(C7), .C8(C8), .C9(C9), .C10(C10), .C11(C11),
        .INCA(INCA), .CLRA(CLRA), .LDA(LDA), .STA(STA), .ADD(ADD), .JMP(JMP),
        .ACC_out(ACC_out), .PC_out(PC_out),
`ifdef TRISC_CARRY_FLAG_EN
        .CARRY(CARRY),
`endif
        .ERR(ERR)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [12:0] s);
        {C42, C11, C10, C9, C8, C7, C6, C5, C4, C3, C2, C1, C0} = s;
    endtask

    // One clock with the given strobes; returns 1 time unit after the edge with strobes idle.
    task automatic cyc(input logic [12:0] s);
        drive(s);
        @(posedge clk);
        #1;
        drive('0);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_acc(input int unsigned v);
        cyc(S_C8);
        repeat (v) cyc(S_C9);
    endtask

    task automatic set_pc(input int unsigned a);
        cyc(S_C0);
        repeat (a) cyc(S_C2);
    endtask

    task automatic write_mem(input int unsigned a, input int unsigned v);
        set_acc(v);
        set_pc(a);
        cyc(S_C4 | S_C5);
    endtask

    // Read mem[PC] into MDR.
    task automatic read_pc(input int unsigned a);
        set_pc(a);
        cyc(S_C4);
        cyc(S_C42);
    endtask

    function automatic logic [5:0] dec();
        return {INCA, CLRA, LDA, STA, ADD, JMP};
    endfunction

    initial begin
        CLR_n = 1'b0;
        drive('0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_acc", 32'(ACC_out), 32'h00);
        chk("rst_pc", 32'(PC_out), 32'h00);
        chk("rst_dec", 32'(dec()), 32'h00);
        chk("rst_err", 32'(ERR), 32'h0);
`ifdef TRISC_CARRY_FLAG_EN
        chk("rst_carry", 32'(CARRY), 32'h0);
`endif
        CLR_n = 1'b1;

        write_mem(0, 8'h00);
        write_mem(1, 8'h4A);
        write_mem(10, 8'h37);
        write_mem(3, 8'h74);
        write_mem(5, 8'h20);
        write_mem(6, 8'hA7);
        write_mem(7, 8'hC5);
        chk("preload_err", 32'(ERR), 32'h0);

        // Fetch of INCA at address 0
        set_pc(0);
        cyc(S_C4);
        cyc(S_C42);
        cyc(S_C2 | S_C7);
        chk("fetch_dec", 32'(dec()), 32'b100000);
        chk("fetch_pc", 32'(PC_out), 32'h01);

        // LDA 10
        cyc(S_C4);
        cyc(S_C42);
        cyc(S_C2 | S_C7);
        chk("lda_dec", 32'(dec()), 32'b001000);
        chk("lda_pc", 32'(PC_out), 32'h02);
        cyc(S_C3 | S_C4);
        cyc(S_C42);
        cyc(S_C11);
        chk("lda_acc", 32'(ACC_out), 32'h37);
        cyc(S_C7);
        chk("clra_dec", 32'(dec()), 32'b010000);

        // STA 20 and readback
        read_pc(3);
        cyc(S_C7);
        chk("sta_dec", 32'(dec()), 32'b000100);
        set_acc(8'h5C);
        cyc(S_C3 | S_C4 | S_C5);
        cyc(S_C3 | S_C4);
        cyc(S_C42);
        cyc(S_C8);
        chk("sta_clr", 32'(ACC_out), 32'h00);
        cyc(S_C11);
        chk("sta_readback", 32'(ACC_out), 32'h5C);

        // ALU add wrap and subtract borrow
        read_pc(5);
        set_acc(8'hF0);
        cyc(S_C10 | S_C11);
        chk("add_wrap", 32'(ACC_out), 32'h10);
`ifdef TRISC_CARRY_FLAG_EN
        chk("add_carry", 32'(CARRY), 32'h1);
`endif
        cyc(S_C6 | S_C10 | S_C11);
        chk("sub_borrow", 32'(ACC_out), 32'hF0);
`ifdef TRISC_CARRY_FLAG_EN
        chk("sub_carry1", 32'(CARRY), 32'h1);
`endif
        cyc(S_C6 | S_C10 | S_C11);
        chk("sub_plain", 32'(ACC_out), 32'hD0);
`ifdef TRISC_CARRY_FLAG_EN
        chk("sub_carry0", 32'(CARRY), 32'h0);
`endif

        // NOP opcode 110
        read_pc(7);
        cyc(S_C7);
        chk("nop_dec", 32'(dec()), 32'h00);

        // JMP decode, PC wrap, jump, conflict
        read_pc(6);
        cyc(S_C7);
        chk("jmp_dec", 32'(dec()), 32'b000001);
        set_pc(31);
        chk("pc_31", 32'(PC_out), 32'd31);
        cyc(S_C2);
        chk("pc_wrap", 32'(PC_out), 32'h00);
        cyc(S_C1);
        chk("pc_jump", 32'(PC_out), 32'h07);
        chk("err_clean", 32'(ERR), 32'h0);
        cyc(S_C0 | S_C2);
        chk("pc_conflict", 32'(PC_out), 32'h00);
        chk("err_pc_set", 32'(ERR), 32'h1);
        repeat (3) cyc('0);
        chk("err_sticky", 32'(ERR), 32'h1);

        // Reset asserted in the cycle after a read
        cyc(S_C1 | S_C7 | S_C9);
        chk("pre_rst_dec", 32'(dec()), 32'b000001);
        cyc(S_C3 | S_C4);
        CLR_n = 1'b0;
        #1;
        chk("midrst_acc", 32'(ACC_out), 32'h00);
        chk("midrst_pc", 32'(PC_out), 32'h00);
        chk("midrst_dec", 32'(dec()), 32'h00);
        chk("midrst_err", 32'(ERR), 32'h0);
        #2;
        CLR_n = 1'b1;
        cyc(S_C9);
        chk("post_rst_inc", 32'(ACC_out), 32'h01);
        cyc(S_C11);
        chk("post_rst_mdr", 32'(ACC_out), 32'h00);
        cyc(S_C7);
        chk("post_rst_ir", 32'(dec()), 32'b100000);

        // ACC strobe conflict: C8 wins, ERR sets
        cyc(S_C9);
        cyc(S_C8 | S_C9);
        chk("acc_conflict", 32'(ACC_out), 32'h00);
        chk("err_acc_set", 32'(ERR), 32'h1);

        // Transfer during write sets ERR
        CLR_n = 1'b0;
        #2;
        CLR_n = 1'b1;
        cyc(S_C42 | S_C4 | S_C5);
        chk("err_xfer_set", 32'(ERR), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
